// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, ALU codes,
// opcode and function-code constants.
package cu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } cu_state_e;

    localparam int CNT_W = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_NOP   = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decoder: opcode/fn_code -> ALU code, legal and nop flags.
// Shift decoding is present only when MULTICYCLE_CU_SHIFT_EN is defined.
module cu_decode
    import cu_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int FN_W   = 6,
    parameter int ALUC_W = 4
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [FN_W-1:0]   fn_code,
    output logic [ALUC_W-1:0] alu_code,
    output logic              legal,
    output logic              nop
);

    function automatic logic [ALUC_W-1:0] zext_code(input logic [3:0] code);
        return ALUC_W'(code);
    endfunction

    logic       is_rtype_s;
    logic       is_nop_s;
    logic       fn_ok_s;
    logic [3:0] fn_code_s;

    assign is_rtype_s = (opcode == OP_W'(OPC_RTYPE));
    assign is_nop_s   = (opcode == {OP_W{1'b1}});

    // R-type function table
    always_comb begin
        fn_code_s = ALU_NOP;
        fn_ok_s   = 1'b0;
        case (fn_code)
            FN_W'(FN_ADD): begin fn_code_s = ALU_ADD; fn_ok_s = 1'b1; end
            FN_W'(FN_SUB): begin fn_code_s = ALU_SUB; fn_ok_s = 1'b1; end
            FN_W'(FN_AND): begin fn_code_s = ALU_AND; fn_ok_s = 1'b1; end
            FN_W'(FN_OR):  begin fn_code_s = ALU_OR;  fn_ok_s = 1'b1; end
`ifdef MULTICYCLE_CU_SHIFT_EN
            FN_W'(FN_SLL): begin fn_code_s = ALU_SLL; fn_ok_s = 1'b1; end
            FN_W'(FN_SRL): begin fn_code_s = ALU_SRL; fn_ok_s = 1'b1; end
`endif
            default:       begin fn_code_s = ALU_NOP; fn_ok_s = 1'b0; end
        endcase
    end

    // Opcode class selects between NOP, R-type and illegal
    always_comb begin
        alu_code = zext_code(ALU_NOP);
        legal    = 1'b0;
        nop      = 1'b0;
        if (is_nop_s) begin
            alu_code = zext_code(ALU_NOP);
            legal    = 1'b1;
            nop      = 1'b1;
        end else if (is_rtype_s && fn_ok_s) begin
            alu_code = zext_code(fn_code_s);
            legal    = 1'b1;
            nop      = 1'b0;
        end else begin
            alu_code = zext_code(ALU_NOP);
            legal    = 1'b0;
            nop      = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle control unit: IDLE -> DECODE -> EXECUTE -> WRITEBACK with registered outputs.
// Optional shift decode enabled by defining MULTICYCLE_CU_SHIFT_EN.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int FN_W      = 6,
    parameter int ALUC_W    = 4,
    parameter int EX_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FN_W-1:0]   fn_code,
    output logic              RegWrite,
    output logic              ALUtoReg,
    output logic [ALUC_W-1:0] alu_control,
    output logic              busy,
    output logic              illegal,
    output logic              done
);

    localparam logic [CNT_W-1:0]  EX_LOAD  = CNT_W'(EX_CYCLES - 1);
    localparam logic [ALUC_W-1:0] ALUC_NOP = ALUC_W'(ALU_NOP);

    cu_state_e         state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [OP_W-1:0]   opcode_r;
    logic [FN_W-1:0]   fn_r;

    logic              ready_r, regwrite_r, alutoreg_r, busy_r, illegal_r, done_r;
    logic [ALUC_W-1:0] aluc_r;
    logic              ready_nxt_s, regwrite_nxt_s, alutoreg_nxt_s, busy_nxt_s;
    logic              illegal_nxt_s, done_nxt_s;
    logic [ALUC_W-1:0] aluc_nxt_s;

    logic              hs_s;
    logic [ALUC_W-1:0] dec_alu_s;
    logic              dec_legal_s, dec_nop_s;

    // ready_r is low for the first edge after reset, so no accept can happen then
    assign hs_s = instr_valid && ready_r;

    cu_decode #(
        .OP_W   (OP_W),
        .FN_W   (FN_W),
        .ALUC_W (ALUC_W)
    ) u_decode (
        .opcode   (opcode_r),
        .fn_code  (fn_r),
        .alu_code (dec_alu_s),
        .legal    (dec_legal_s),
        .nop      (dec_nop_s)
    );

    // Next state, counter and next registered outputs
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        regwrite_nxt_s = 1'b0;
        done_nxt_s     = 1'b0;
        illegal_nxt_s  = 1'b0;
        alutoreg_nxt_s = alutoreg_r;
        aluc_nxt_s     = aluc_r;
        case (state_r)
            ST_IDLE: begin
                alutoreg_nxt_s = 1'b0;
                aluc_nxt_s     = ALUC_NOP;
                if (hs_s) begin
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                cnt_nxt_s = EX_LOAD;
                if (!dec_legal_s) begin
                    state_nxt_s    = ST_IDLE;
                    illegal_nxt_s  = 1'b1;
                    alutoreg_nxt_s = 1'b0;
                    aluc_nxt_s     = ALUC_NOP;
                end else if (dec_nop_s) begin
                    state_nxt_s    = ST_WRITEBACK;
                    done_nxt_s     = 1'b1;
                    alutoreg_nxt_s = 1'b0;
                    aluc_nxt_s     = ALUC_NOP;
                end else begin
                    state_nxt_s    = ST_EXECUTE;
                    alutoreg_nxt_s = 1'b1;
                    aluc_nxt_s     = dec_alu_s;
                end
            end
            ST_EXECUTE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s    = ST_WRITEBACK;
                    regwrite_nxt_s = 1'b1;
                    done_nxt_s     = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WRITEBACK: begin
                state_nxt_s    = ST_IDLE;
                cnt_nxt_s      = {CNT_W{1'b0}};
                alutoreg_nxt_s = 1'b0;
                aluc_nxt_s     = ALUC_NOP;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                cnt_nxt_s      = {CNT_W{1'b0}};
                alutoreg_nxt_s = 1'b0;
                aluc_nxt_s     = ALUC_NOP;
            end
        endcase
    end

    // Ready/busy follow the state being entered so they line up with it
    always_comb begin
        if (state_nxt_s == ST_IDLE) begin
            ready_nxt_s = 1'b1;
            busy_nxt_s  = 1'b0;
        end else begin
            ready_nxt_s = 1'b0;
            busy_nxt_s  = 1'b1;
        end
    end

    // State, counter and latched instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            opcode_r <= {OP_W{1'b0}};
            fn_r     <= {FN_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (hs_s) begin
                opcode_r <= opcode;
                fn_r     <= fn_code;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r    <= 1'b0;
            regwrite_r <= 1'b0;
            alutoreg_r <= 1'b0;
            aluc_r     <= ALUC_NOP;
            busy_r     <= 1'b0;
            illegal_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            ready_r    <= ready_nxt_s;
            regwrite_r <= regwrite_nxt_s;
            alutoreg_r <= alutoreg_nxt_s;
            aluc_r     <= aluc_nxt_s;
            busy_r     <= busy_nxt_s;
            illegal_r  <= illegal_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign instr_ready = ready_r;
    assign RegWrite    = regwrite_r;
    assign ALUtoReg    = alutoreg_r;
    assign alu_control = aluc_r;
    assign busy        = busy_r;
    assign illegal     = illegal_r;
    assign done        = done_r;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: dut0 with EX_CYCLES=1, dut1 with EX_CYCLES=4.
module tb_multicycle_cu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst  [2];
    logic       v    [2];
    logic [5:0] op   [2];
    logic [5:0] fn   [2];
    logic       rdy  [2];
    logic       rw   [2];
    logic       a2r  [2];
    logic       bsy  [2];
    logic       ill  [2];
    logic       dn   [2];
    logic [3:0] aluc [2];

    multicycle_cu #(.EX_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst[0]), .instr_valid(v[0]), .instr_ready(rdy[0]),
        .opcode(op[0]), .fn_code(fn[0]), .RegWrite(rw[0]), .ALUtoReg(a2r[0]),
        .alu_control(aluc[0]), .busy(bsy[0]), .illegal(ill[0]), .done(dn[0])
    );

    multicycle_cu #(.EX_CYCLES(4)) dut1 (
        .clk(clk), .rst(rst[1]), .instr_valid(v[1]), .instr_ready(rdy[1]),
        .opcode(op[1]), .fn_code(fn[1]), .RegWrite(rw[1]), .ALUtoReg(a2r[1]),
        .alu_control(aluc[1]), .busy(bsy[1]), .illegal(ill[1]), .done(dn[1])
    );

    typedef struct {
        logic       is_ill;
        logic       rw;
        logic       a2r;
        logic [3:0] aluc;
        int         due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h want=%0h cyc=%0d", name, d, act, exp, cyc);
        end
    endtask

    task automatic reset_chk(input int d);
        chk("rst_ready", d, rdy[d], 1'b0);
        chk("rst_regwrite", d, rw[d], 1'b0);
        chk("rst_alutoreg", d, a2r[d], 1'b0);
        chk("rst_alu_control", d, aluc[d], 4'hF);
        chk("rst_busy", d, bsy[d], 1'b0);
        chk("rst_illegal", d, ill[d], 1'b0);
        chk("rst_done", d, dn[d], 1'b0);
    endtask

    // Monitor: pop expected event whenever done or illegal pulses
    task automatic mon_one(input int d);
        exp_t e;
        int   qs;
        qs = (d == 0) ? q0.size() : q1.size();
        if (dn[d] === 1'b1 || ill[d] === 1'b1) begin
            if (qs == 0) begin
                chk("unexpected_event", d, {30'd0, dn[d], ill[d]}, 32'd0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk("event_illegal", d, ill[d], e.is_ill);
                chk("event_done", d, dn[d], !e.is_ill);
                chk("event_regwrite", d, rw[d], e.rw);
                chk("event_alutoreg", d, a2r[d], e.a2r);
                chk("event_alu_control", d, aluc[d], e.aluc);
                chk("event_cycle", d, cyc, e.due);
                if (e.is_ill) chk("ready_with_illegal", d, rdy[d], 1'b1);
            end
        end
        if (rw[d] === 1'b1 && dn[d] !== 1'b1) chk("regwrite_without_done", d, rw[d], 1'b0);
    endtask

    always @(negedge clk) begin
        mon_one(0);
        mon_one(1);
    end

    // kind: 0 retire (done), 1 illegal, 2 no event expected (aborted)
    // off: event negedge lands at handshake cycle + off
    task automatic issue(input int d, input logic [5:0] o, input logic [5:0] f, input int kind,
                         input logic [3:0] ac, input int nexec, input int off, input bit hold,
                         output int t);
        exp_t e;
        int   n;
        n = 0;
        while (rdy[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", d, rdy[d], 1'b1);
        v[d]  = 1'b1;
        op[d] = o;
        fn[d] = f;
        @(posedge clk);
        #1;
        t = cyc;
        if (kind != 2) begin
            e.is_ill = (kind == 1);
            e.rw     = (kind == 0) && (ac != 4'hF);
            e.a2r    = (kind == 0) && (ac != 4'hF);
            e.aluc   = ac;
            e.due    = t + off;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        chk("decode_busy", d, bsy[d], 1'b1);
        chk("decode_ready", d, rdy[d], 1'b0);
        if (!hold) begin
            v[d]  = 1'b0;
            op[d] = 6'b000001;
            fn[d] = 6'b101010;
        end
        for (int k = 0; k < nexec; k++) begin
            @(negedge clk);
            chk("exec_alu_control", d, aluc[d], ac);
            chk("exec_alutoreg", d, a2r[d], 1'b1);
            chk("exec_regwrite", d, rw[d], 1'b0);
            chk("exec_busy", d, bsy[d], 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int t2;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            v[d]   = 1'b1;
            op[d]  = 6'b000000;
            fn[d]  = 6'b100000;
        end
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) reset_chk(d);
        end
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            v[d]   = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("ready_after_rst", d, rdy[d], 1'b1);

        // ADD, EX_CYCLES=1: retire at handshake+2, ready again at handshake+3
        issue(0, 6'b000000, 6'b100000, 0, 4'b0010, 1, 2, 1'b0, t);
        @(negedge clk);
        chk("ready_in_writeback", 0, rdy[0], 1'b0);
        @(negedge clk);
        chk("ready_returns", 0, rdy[0], 1'b1);
        chk("ready_return_cycle", 0, cyc, t + 3);

        issue(0, 6'b000000, 6'b100010, 0, 4'b0110, 1, 2, 1'b0, t);
        issue(0, 6'b000000, 6'b100100, 0, 4'b0000, 1, 2, 1'b0, t);
        issue(0, 6'b000000, 6'b100101, 0, 4'b0001, 1, 2, 1'b0, t);
`ifdef MULTICYCLE_CU_SHIFT_EN
        issue(0, 6'b000000, 6'b000000, 0, 4'b0011, 1, 2, 1'b0, t);
        issue(0, 6'b000000, 6'b000010, 0, 4'b0100, 1, 2, 1'b0, t);
`else
        issue(0, 6'b000000, 6'b000000, 1, 4'b1111, 0, 1, 1'b0, t);
        issue(0, 6'b000000, 6'b000010, 1, 4'b1111, 0, 1, 1'b0, t);
`endif
        // NOP skips EXECUTE
        issue(0, 6'b111111, 6'b000000, 0, 4'b1111, 0, 1, 1'b0, t);
        // Illegal opcode, then R-type with unlisted fn
        issue(0, 6'b000001, 6'b100000, 1, 4'b1111, 0, 1, 1'b0, t);
        issue(0, 6'b000000, 6'b101010, 1, 4'b1111, 0, 1, 1'b0, t);

        // EX_CYCLES=4, SUB with instr_valid held: next accept seven edges later
        issue(1, 6'b000000, 6'b100010, 0, 4'b0110, 4, 5, 1'b1, t);
        issue(1, 6'b000000, 6'b100010, 0, 4'b0110, 4, 5, 1'b1, t2);
        chk("back_to_back_accept", 1, t2 - t, 7);
        v[1] = 1'b0;

        // Reset during EXECUTE of OR aborts with no pulses
        issue(1, 6'b000000, 6'b100101, 2, 4'b0001, 1, 0, 1'b0, t);
        rst[1] = 1'b1;
        @(negedge clk);
        reset_chk(1);
        rst[1] = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 1, rdy[1], 1'b1);

        repeat (10) @(negedge clk);
        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 SHALL have parameter OP_W, default 6: opcode width.
REQ-002 SHALL have parameter FN_W, default 6: function-code width.
REQ-003 SHALL have parameter ALUC_W, default 4 (min 4): alu_control width; codes zero-extended.
REQ-004 SHALL have parameter EX_CYCLES, default 1, legal 1..15: cycles spent in EXECUTE.
REQ-005 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port instr_valid  input  1: opcode/fn_code valid.
REQ-008 SHALL have port instr_ready  output  1: unit can accept an instruction.
REQ-009 SHALL have port opcode  input  OP_W: instruction opcode.
REQ-010 SHALL have port fn_code  input  FN_W: R-type function field.
REQ-011 SHALL have port RegWrite  output  1: register-file write enable.
REQ-012 SHALL have port ALUtoReg  output  1: select ALU result as writeback data.
REQ-013 SHALL have port alu_control  output  ALUC_W: ALU operation code.
REQ-014 SHALL have port busy  output  1: instruction in flight.
REQ-015 SHALL have port illegal  output  1: one-cycle pulse, undecodable instruction.
REQ-016 SHALL have port done  output  1: one-cycle pulse, instruction retired.

Function
REQ-017 SHALL implement FSM IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE; all outputs registered or decoded from state only.
REQ-018 SHALL assert instr_ready only in IDLE and not during rst; handshake = instr_valid && instr_ready on a rising edge; opcode/fn_code latched then, ignored afterwards until next IDLE.
REQ-019 SHALL decode, with opcode all-zeros (R-type): fn 100000 ADD=0010, 100010 SUB=0110, 100100 AND=0000, 100101 OR=0001, 000000 SLL=0011, 000010 SRL=0100.
REQ-020 SHALL treat opcode all-ones as NOP: DECODE -> WRITEBACK directly, RegWrite=0, ALUtoReg=0, alu_control=1111, done pulses.
REQ-021 SHALL treat any other opcode, or R-type with unlisted fn_code, as illegal: DECODE -> IDLE, illegal=1 for exactly one cycle, done=0, RegWrite never asserted.
REQ-022 SHALL hold alu_control at decoded code and ALUtoReg=1 from first EXECUTE cycle through WRITEBACK; alu_control=1111 in IDLE.
REQ-023 SHALL stay in EXECUTE exactly EX_CYCLES cycles via a down-counter loaded in DECODE.
REQ-024 SHALL assert RegWrite and done for exactly one cycle, in WRITEBACK, for legal R-type.
REQ-025 SHALL give latency: handshake edge T, DECODE T+1, EXECUTE T+2..T+1+EX_CYCLES, WRITEBACK T+2+EX_CYCLES, instr_ready high again at T+3+EX_CYCLES; no back-to-back overlap.
REQ-026 SHALL assert busy in every non-IDLE state.
REQ-027 SHALL ignore instr_valid changes while busy; instr_valid=1 held continuously yields one accepted instruction per pass through IDLE.

Reset
REQ-028 SHALL, while rst=1 at a rising edge, enter IDLE and clear counter and latched instruction.
REQ-029 SHALL reset outputs to: instr_ready=0 (during rst), RegWrite=0, ALUtoReg=0, alu_control=1111, busy=0, illegal=0, done=0.
REQ-030 SHALL abort any in-flight instruction on rst mid-operation with no RegWrite/done/illegal pulse; instr_ready=1 first cycle after rst falls.

Configuration
REQ-031 SHALL, with macro MULTICYCLE_CU_SHIFT_EN defined, decode SLL/SRL per REQ-019.
REQ-032 SHALL, without MULTICYCLE_CU_SHIFT_EN, treat fn 000000 and 000010 as illegal per REQ-021.

Structure
REQ-033 SHALL place FSM state enum, ALU code constants (AND, OR, ADD, SUB, SLL, SRL, NOP=1111), R-type/NOP opcodes and fn-code constants in shared package cu_pkg.
REQ-034 SHALL contain one sub-module cu_decode (combinational opcode/fn_code -> alu code, legal, nop flags); FSM and counter remain in multicycle_cu.

Verification
REQ-035 SHALL check reset: rst=1 two cycles with instr_valid=1 -> no handshake, outputs per REQ-029; rst=0 -> instr_ready=1 next cycle.
REQ-036 SHALL check ADD, EX_CYCLES=1: opcode 000000 fn 100000 accepted at T -> alu_control=0010, ALUtoReg=1 at T+2; RegWrite=1, done=1 only at T+3; instr_ready=1 at T+4.
REQ-037 SHALL check all six R-type codes and NOP (opcode 111111 -> done at T+2, RegWrite=0, alu_control=1111).
REQ-038 SHALL check illegal: opcode 000001, then opcode 000000 fn 101010 -> illegal single pulse at T+2, no RegWrite, back in IDLE; without MULTICYCLE_CU_SHIFT_EN fn 000010 -> illegal.
REQ-039 SHALL check EX_CYCLES=4: SUB -> alu_control=0110 held 4 EXECUTE cycles, RegWrite at T+6; instr_valid held high -> next accept at T+7.
REQ-040 SHALL check rst asserted during EXECUTE of OR -> no RegWrite/done ever, outputs per REQ-029 next edge.
